// File: rtl/gmii_demux_pkg.sv
// -----------------------------------------------------------------------------
// gmii_demux_pkg
//   Shared definitions for the GMII RX demultiplexer: FSM state encoding, GMII
//   byte width, default output count and the select range check.
// -----------------------------------------------------------------------------
package gmii_demux_pkg;

   localparam int unsigned GmiiWidth     = 8;
   localparam int unsigned DefNumOutputs = 5;

   typedef enum logic [1:0] {
      StSync    = 2'd0,
      StIdle    = 2'd1,
      StFrame   = 2'd2,
      StDiscard = 2'd3
   } state_e;

   // A select value addresses a real output only when it is below the output count.
   function automatic logic sel_valid(input logic [7:0] sel, input int unsigned num);
      return 32'(sel) < num;
   endfunction

endpackage

// File: rtl/gmii_demux_if.sv
// -----------------------------------------------------------------------------
// gmii_demux_if
//   Bundles the GMII RX input, the output fan-out and the statistics of the
//   demultiplexer.
//   master : drives gmii_in_* and select, observes outputs and statistics
//   slave  : the demultiplexer side
//   gmii_out_rxd packs output n in bits [8n+7:8n].
// -----------------------------------------------------------------------------
interface gmii_demux_if #(
   parameter int unsigned C_NUM_OUTPUTS = 5,
   parameter int unsigned C_CNT_WIDTH   = 32
);
   logic [7:0]                 gmii_in_rxd;
   logic                       gmii_in_rx_dv;
   logic                       gmii_in_rx_er;
   logic [7:0]                 select;
   logic [8*C_NUM_OUTPUTS-1:0] gmii_out_rxd;
   logic [C_NUM_OUTPUTS-1:0]   gmii_out_rx_dv;
   logic [C_NUM_OUTPUTS-1:0]   gmii_out_rx_er;
   logic [7:0]                 active_sel;
   logic [C_CNT_WIDTH-1:0]     frame_cnt;
   logic [C_CNT_WIDTH-1:0]     err_frame_cnt;
   logic [C_CNT_WIDTH-1:0]     drop_cnt;

   modport master (
      output gmii_in_rxd, gmii_in_rx_dv, gmii_in_rx_er, select,
      input  gmii_out_rxd, gmii_out_rx_dv, gmii_out_rx_er, active_sel,
      input  frame_cnt, err_frame_cnt, drop_cnt
   );

   modport slave (
      input  gmii_in_rxd, gmii_in_rx_dv, gmii_in_rx_er, select,
      output gmii_out_rxd, gmii_out_rx_dv, gmii_out_rx_er, active_sel,
      output frame_cnt, err_frame_cnt, drop_cnt
   );
endinterface

// File: rtl/gmii_demux_stat_cnt.sv
// -----------------------------------------------------------------------------
// gmii_demux_stat_cnt
//   Wrapping statistics counter.
//   gtx_clk : clock
//   reset   : asynchronous active-high reset, clears the count
//   i_inc   : increment strobe (one per cycle)
//   o_cnt   : current count, wraps modulo 2^C_CNT_WIDTH
// -----------------------------------------------------------------------------
module gmii_demux_stat_cnt #(
   parameter int unsigned C_CNT_WIDTH = 32
) (
   input  logic                   gtx_clk,
   input  logic                   reset,
   input  logic                   i_inc,
   output logic [C_CNT_WIDTH-1:0] o_cnt
);

   logic [C_CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge gtx_clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + C_CNT_WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/gmii_demux.sv
// -----------------------------------------------------------------------------
// gmii_demux
//   Fans one GMII RX stream out to one of C_NUM_OUTPUTS consumers, switching
//   only on frame boundaries. Fixed two-cycle latency (input register, output
//   register). Counts forwarded, errored and dropped frames.
//   gtx_clk : 125 MHz GMII clock
//   reset   : asynchronous active-high reset
//   io_gmii : slave side of gmii_demux_if (RX input, select, outputs, stats)
// -----------------------------------------------------------------------------
module gmii_demux
   import gmii_demux_pkg::*;
#(
   parameter int unsigned C_NUM_OUTPUTS = DefNumOutputs,
   parameter int unsigned C_CNT_WIDTH   = 32
) (
   input logic         gtx_clk,
   input logic         reset,
   gmii_demux_if.slave io_gmii
);

   // Stage 1 registers
   logic [7:0] r_rxd;
   logic       r_dv;
   logic       r_er;
   logic [7:0] r_sel;
   // Set one cycle after reset so SYNC never acts on the reset value of r_dv.
   logic       r_primed;

   // FSM state
   state_e     r_state;
   logic [7:0] r_active_sel;
   logic       r_er_seen;

   // Stage 2 output registers
   logic [8*C_NUM_OUTPUTS-1:0] r_out_rxd;
   logic [C_NUM_OUTPUTS-1:0]   r_out_dv;
   logic [C_NUM_OUTPUTS-1:0]   r_out_er;

   logic [7:0]                 w_route;
   logic                       w_sel_ok;
   logic                       w_fwd;
   logic                       w_inc_frame;
   logic                       w_inc_err;
   logic                       w_inc_drop;
   logic [8*C_NUM_OUTPUTS-1:0] w_out_rxd;
   logic [C_NUM_OUTPUTS-1:0]   w_out_dv;
   logic [C_NUM_OUTPUTS-1:0]   w_out_er;

   always_ff @(posedge gtx_clk or posedge reset) begin
      if (reset) begin
         r_rxd    <= '0;
         r_dv     <= 1'b0;
         r_er     <= 1'b0;
         r_sel    <= '0;
         r_primed <= 1'b0;
      end else begin
         r_rxd    <= io_gmii.gmii_in_rxd;
         r_dv     <= io_gmii.gmii_in_rx_dv;
         r_er     <= io_gmii.gmii_in_rx_er;
         r_sel    <= io_gmii.select;
         r_primed <= 1'b1;
      end
   end

   assign w_sel_ok = sel_valid(r_sel, C_NUM_OUTPUTS);
   assign w_route  = (r_state == StIdle) ? r_sel : r_active_sel;
   // The first byte is forwarded in the same cycle the frame start is detected.
   assign w_fwd    = (r_state == StFrame) || ((r_state == StIdle) && r_dv && w_sel_ok);

   assign w_inc_frame = (r_state == StFrame) && !r_dv;
   assign w_inc_err   = w_inc_frame && r_er_seen;
   assign w_inc_drop  = (r_state == StDiscard) && !r_dv;

   always_ff @(posedge gtx_clk or posedge reset) begin
      if (reset) begin
         r_state      <= StSync;
         r_active_sel <= '0;
         r_er_seen    <= 1'b0;
      end else begin
         unique case (r_state)
            // Wait out any frame that was in flight when reset released.
            StSync: begin
               if (r_primed && !r_dv) r_state <= StIdle;
            end
            StIdle: begin
               if (r_dv) begin
                  r_active_sel <= r_sel;
                  r_er_seen    <= r_er;
                  r_state      <= w_sel_ok ? StFrame : StDiscard;
               end
            end
            StFrame: begin
               if (r_dv) begin
                  r_er_seen <= r_er_seen | r_er;
               end else begin
                  r_state <= StIdle;
               end
            end
            StDiscard: begin
               if (!r_dv) r_state <= StIdle;
            end
            default: r_state <= StSync;
         endcase
      end
   end

   always_comb begin
      w_out_rxd = '0;
      w_out_dv  = '0;
      w_out_er  = '0;
      for (int n = 0; n < int'(C_NUM_OUTPUTS); n++) begin
         if (w_fwd && (w_route == 8'(n))) begin
            w_out_rxd[n*GmiiWidth +: GmiiWidth] = r_rxd;
            w_out_dv[n] = r_dv;
            w_out_er[n] = r_er;
         end
      end
   end

   always_ff @(posedge gtx_clk or posedge reset) begin
      if (reset) begin
         r_out_rxd <= '0;
         r_out_dv  <= '0;
         r_out_er  <= '0;
      end else begin
         r_out_rxd <= w_out_rxd;
         r_out_dv  <= w_out_dv;
         r_out_er  <= w_out_er;
      end
   end

   assign io_gmii.gmii_out_rxd   = r_out_rxd;
   assign io_gmii.gmii_out_rx_dv = r_out_dv;
   assign io_gmii.gmii_out_rx_er = r_out_er;
   assign io_gmii.active_sel     = r_active_sel;

   gmii_demux_stat_cnt #(
      .C_CNT_WIDTH (C_CNT_WIDTH)
   ) u_frame_cnt (
      .gtx_clk (gtx_clk),
      .reset   (reset),
      .i_inc   (w_inc_frame),
      .o_cnt   (io_gmii.frame_cnt)
   );

   gmii_demux_stat_cnt #(
      .C_CNT_WIDTH (C_CNT_WIDTH)
   ) u_err_frame_cnt (
      .gtx_clk (gtx_clk),
      .reset   (reset),
      .i_inc   (w_inc_err),
      .o_cnt   (io_gmii.err_frame_cnt)
   );

   gmii_demux_stat_cnt #(
      .C_CNT_WIDTH (C_CNT_WIDTH)
   ) u_drop_cnt (
      .gtx_clk (gtx_clk),
      .reset   (reset),
      .i_inc   (w_inc_drop),
      .o_cnt   (io_gmii.drop_cnt)
   );

endmodule

// File: tb/tb_gmii_demux.sv
// -----------------------------------------------------------------------------
// tb_gmii_demux
//   Randomized and directed stimulus against a per-byte routing model of the
//   demultiplexer; every cycle the outputs, active_sel and statistics are
//   compared with the model's prediction.
// -----------------------------------------------------------------------------
module tb_gmii_demux;

   localparam int N  = 5;
   localparam int CW = 4;  // narrow counters so the random phase wraps them

   typedef struct {
      logic [8*N-1:0] rxd;
      logic [N-1:0]   dv;
      logic [N-1:0]   er;
      logic [7:0]     act;
      int unsigned    fc;
      int unsigned    ec;
      int unsigned    dc;
   } snap_t;

   logic gtx_clk;
   logic reset;

   gmii_demux_if #(.C_NUM_OUTPUTS(N), .C_CNT_WIDTH(CW)) bus ();

   gmii_demux #(
      .C_NUM_OUTPUTS (N),
      .C_CNT_WIDTH   (CW)
   ) dut (
      .gtx_clk (gtx_clk),
      .reset   (reset),
      .io_gmii (bus.slave)
   );

   initial gtx_clk = 1'b0;
   always #4 gtx_clk = ~gtx_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: where the frame currently on the wire is going.
   bit          m_synced;
   bit          m_in_frame;
   int          m_dest;     // -1 = frame is being dropped
   bit          m_err;
   logic [7:0]  m_act;
   int unsigned m_fc, m_ec, m_dc;
   snap_t       pend;

   localparam logic [63:0] CntMask = (64'd1 << CW) - 64'd1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic snap_t zero_snap();
      snap_t s;
      s.rxd = '0; s.dv = '0; s.er = '0; s.act = '0; s.fc = 0; s.ec = 0; s.dc = 0;
      return s;
   endfunction

   task automatic model_reset();
      m_synced = 0; m_in_frame = 0; m_dest = -1; m_err = 0; m_act = '0;
      m_fc = 0; m_ec = 0; m_dc = 0;
      pend = zero_snap();
   endtask

   // Predict what the outputs show for one input byte (they appear two edges later).
   task automatic model_step(input bit dv, input bit er, input logic [7:0] rxd,
                             input logic [7:0] sel, output snap_t s);
      s = zero_snap();
      if (!m_synced) begin
         if (!dv) m_synced = 1;
      end else if (!m_in_frame) begin
         if (dv) begin
            m_in_frame = 1;
            m_act      = sel;
            m_dest     = (int'(sel) < N) ? int'(sel) : -1;
            m_err      = er;
            if (m_dest >= 0) begin
               s.rxd[m_dest*8 +: 8] = rxd; s.dv[m_dest] = dv; s.er[m_dest] = er;
            end
         end
      end else begin
         if (m_dest >= 0) begin
            s.rxd[m_dest*8 +: 8] = rxd; s.dv[m_dest] = dv; s.er[m_dest] = er;
         end
         if (dv) begin
            m_err = m_err | er;
         end else begin
            m_in_frame = 0;
            if (m_dest >= 0) begin
               m_fc++;
               if (m_err) m_ec++;
            end else begin
               m_dc++;
            end
         end
      end
      s.act = m_act; s.fc = m_fc; s.ec = m_ec; s.dc = m_dc;
   endtask

   task automatic check_snap(input snap_t s);
      check_eq("out_rxd", 64'(bus.gmii_out_rxd), 64'(s.rxd));
      check_eq("out_dv", 64'(bus.gmii_out_rx_dv), 64'(s.dv));
      check_eq("out_er", 64'(bus.gmii_out_rx_er), 64'(s.er));
      check_eq("active_sel", 64'(bus.active_sel), 64'(s.act));
      check_eq("frame_cnt", 64'(bus.frame_cnt), 64'(s.fc) & CntMask);
      check_eq("err_frame_cnt", 64'(bus.err_frame_cnt), 64'(s.ec) & CntMask);
      check_eq("drop_cnt", 64'(bus.drop_cnt), 64'(s.dc) & CntMask);
   endtask

   // Starts and ends at a falling edge; one input byte per call.
   task automatic drive(input bit dv, input bit er, input logic [7:0] rxd,
                        input logic [7:0] sel);
      snap_t s;
      bus.gmii_in_rx_dv = dv;
      bus.gmii_in_rx_er = er;
      bus.gmii_in_rxd   = rxd;
      bus.select        = sel;
      model_step(dv, er, rxd, sel, s);
      @(posedge gtx_clk);
      #1;
      check_snap(pend);
      pend = s;
      @(negedge gtx_clk);
   endtask

   task automatic idle(input int n, input logic [7:0] sel);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom), sel);
   endtask

   task automatic send_frame(input int len, input logic [7:0] s0, input int chg_at,
                             input logic [7:0] s1, input int er_at, input int ifg);
      for (int i = 0; i < len; i++) begin
         drive(1'b1, (i == er_at), 8'($urandom), (i >= chg_at) ? s1 : s0);
      end
      idle(ifg, s1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_snap(zero_snap());
      @(negedge gtx_clk);
      @(negedge gtx_clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset             = 1'b1;
      bus.gmii_in_rxd   = '0;
      bus.gmii_in_rx_dv = 1'b0;
      bus.gmii_in_rx_er = 1'b0;
      bus.select        = '0;
      model_reset();
      @(negedge gtx_clk);
      do_reset();
      idle(3, 8'd0);

      // 1: plain 64-byte frame to output 2
      send_frame(64, 8'd2, 1000, 8'd2, -1, 2);
      idle(1, 8'd2);
      check_eq("t1_frame_cnt", 64'(bus.frame_cnt), 64'd1);

      // 2: select changes mid-frame, takes effect on the next frame
      send_frame(100, 8'd1, 10, 8'd3, -1, 3);
      send_frame(20, 8'd3, 1000, 8'd3, -1, 2);
      idle(1, 8'd3);
      check_eq("t2_active_sel", 64'(bus.active_sel), 64'd3);
      check_eq("t2_frame_cnt", 64'(bus.frame_cnt), 64'd3);

      // 3: invalid select drops frames
      send_frame(30, 8'd7, 1000, 8'd7, -1, 2);
      send_frame(30, 8'd7, 1000, 8'd7, -1, 2);
      idle(1, 8'd7);
      check_eq("t3_drop_cnt", 64'(bus.drop_cnt), 64'd2);
      check_eq("t3_frame_cnt", 64'(bus.frame_cnt), 64'd3);

      // 4: single errored byte
      send_frame(40, 8'd0, 1000, 8'd0, 20, 2);
      idle(1, 8'd0);
      check_eq("t4_err_frame_cnt", 64'(bus.err_frame_cnt), 64'd1);
      check_eq("t4_frame_cnt", 64'(bus.frame_cnt), 64'd4);

      // 5: reset mid-frame, released while dv is still high
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 8'($urandom), 8'd2);
      do_reset();
      send_frame(20, 8'd2, 1000, 8'd2, -1, 2);
      send_frame(30, 8'd2, 1000, 8'd2, -1, 2);
      idle(1, 8'd2);
      check_eq("t5_frame_cnt", 64'(bus.frame_cnt), 64'd1);
      check_eq("t5_drop_cnt", 64'(bus.drop_cnt), 64'd0);

      // 6: back-to-back frames, select toggled in the single-cycle gap
      send_frame(25, 8'd0, 1000, 8'd4, -1, 1);
      send_frame(25, 8'd4, 1000, 8'd4, -1, 2);
      idle(1, 8'd4);
      check_eq("t6_frame_cnt", 64'(bus.frame_cnt), 64'd3);
      check_eq("t6_active_sel", 64'(bus.active_sel), 64'd4);

      // Random frames: lengths, selects (valid and invalid), mid-frame select
      // changes, errors, short gaps and false carrier; counters wrap.
      for (int f = 0; f < 60; f++) begin
         int          len;
         int          chg;
         int          er_at;
         logic [7:0]  s0;
         logic [7:0]  s1;
         len   = int'($urandom_range(1, 24));
         chg   = int'($urandom_range(0, 30));
         er_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 23)) : -1;
         s0    = 8'($urandom_range(0, 7));
         s1    = 8'($urandom_range(0, 7));
         send_frame(len, s0, chg, s1, er_at, int'($urandom_range(1, 3)));
         if ($urandom_range(0, 4) == 0) begin
            drive(1'b0, 1'b1, 8'($urandom), s1);
            idle(1, s1);
         end
      end
      idle(3, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
